fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the unpipelined RISC-V datapath (`fullDataPath`). It owns the PC register, issues word reads to a synchronous instruction memory, and buffers returned instructions in a small queue. Instructions are presented to the datapath with a valid/ready handshake. The datapath's taken-branch/jump target comes back as a redirect that flushes all stale fetches.

---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and datapath-handshake signals of the fetch stage.
interface fetch_unit_if;
  import riscv_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] fetch_pc;
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, fetch_pc, misalign_err,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, fetch_pc, misalign_err,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with synchronous flush; Depth must be a power of two.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned  Depth = 2,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  fetch_entry_t    data_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && !flush_i && count_q == CntW'(Depth)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, word-read issue, in-flight tracking, redirect squash.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            misalign_q, misalign_d;

  logic [CntW-1:0] count;
  logic [OccW-1:0] occupancy;
  logic            out_valid, pop, push, issue;
  fetch_entry_t    head, push_entry;

  assign out_valid = (count != '0);
  assign pop       = out_valid & bus.out_ready;
  // A response landing in a redirect cycle belongs to the old path.
  assign push      = inflight_q & ~bus.redirect_valid;
  assign occupancy = OccW'(count) + OccW'(inflight_q) - OccW'(pop);
  assign issue     = ~rst & ~bus.redirect_valid & (occupancy < OccW'(QDEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    misalign_d    = misalign_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      misalign_d = misalign_q | (|bus.redirect_pc[1:0]);
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      misalign_q    <= misalign_d;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = out_valid;
  assign bus.out_pc       = head.pc;
  assign bus.out_instr    = head.instr;
  assign bus.fetch_pc     = fetch_pc_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed per-cycle vector bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;
  import riscv_fetch_pkg::*;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] fpc;
    logic        ov;
    logic [63:0] opc;
    logic        mis;
  } row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (64'h0),
    .QDEPTH   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h0001_0013;
  endfunction

  // Synchronous memory: data only in the cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;
  end

  function automatic row_t mk(input logic rdy, input logic rv, input logic [63:0] rpc,
                              input logic req, input logic [63:0] fpc, input logic ov,
                              input logic [63:0] opc, input logic mis);
    row_t r;
    r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.req = req;
    r.fpc = fpc; r.ov = ov; r.opc = opc; r.mis = mis;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_row(input string tag, input int i, input row_t r);
    string p;
    p = $sformatf("%s[%0d]", tag, i);
    check({p, ".imem_req"}, 64'(bus.imem_req), 64'(r.req));
    check({p, ".fetch_pc"}, bus.fetch_pc, r.fpc);
    if (r.req) check({p, ".imem_addr"}, bus.imem_addr, r.fpc);
    check({p, ".out_valid"}, 64'(bus.out_valid), 64'(r.ov));
    if (r.ov) begin
      check({p, ".out_pc"}, bus.out_pc, r.opc);
      check({p, ".out_instr"}, 64'(bus.out_instr), 64'(instr_of(r.opc)));
    end
    check({p, ".misalign_err"}, 64'(bus.misalign_err), 64'(r.mis));
  endtask

  row_t main_tbl[25];
  row_t bp_tbl[10];

  initial begin
    // Stream, backpressure, redirect on full path, redirect+pop, misaligned redirect.
    main_tbl[0]  = mk(1, 0, 0,        1, 'h0,   0, 0,      0);
    main_tbl[1]  = mk(1, 0, 0,        1, 'h4,   0, 0,      0);
    main_tbl[2]  = mk(1, 0, 0,        1, 'h8,   1, 'h0,    0);
    main_tbl[3]  = mk(1, 0, 0,        1, 'hC,   1, 'h4,    0);
    main_tbl[4]  = mk(0, 0, 0,        0, 'h10,  1, 'h8,    0);
    main_tbl[5]  = mk(0, 0, 0,        0, 'h10,  1, 'h8,    0);
    main_tbl[6]  = mk(1, 0, 0,        1, 'h10,  1, 'h8,    0);
    main_tbl[7]  = mk(1, 0, 0,        1, 'h14,  1, 'hC,    0);
    main_tbl[8]  = mk(0, 1, 'h40,     0, 'h18,  1, 'h10,   0);
    main_tbl[9]  = mk(1, 0, 0,        1, 'h40,  0, 0,      0);
    main_tbl[10] = mk(1, 0, 0,        1, 'h44,  0, 0,      0);
    main_tbl[11] = mk(1, 0, 0,        1, 'h48,  1, 'h40,   0);
    main_tbl[12] = mk(1, 0, 0,        1, 'h4C,  1, 'h44,   0);
    main_tbl[13] = mk(1, 1, 'h100,    0, 'h50,  1, 'h48,   0);
    main_tbl[14] = mk(1, 0, 0,        1, 'h100, 0, 0,      0);
    main_tbl[15] = mk(1, 0, 0,        1, 'h104, 0, 0,      0);
    main_tbl[16] = mk(1, 0, 0,        1, 'h108, 1, 'h100,  0);
    main_tbl[17] = mk(1, 1, 'h42,     0, 'h10C, 1, 'h104,  0);
    main_tbl[18] = mk(1, 0, 0,        1, 'h40,  0, 0,      1);
    main_tbl[19] = mk(1, 0, 0,        1, 'h44,  0, 0,      1);
    main_tbl[20] = mk(1, 0, 0,        1, 'h48,  1, 'h40,   1);
    main_tbl[21] = mk(1, 1, 'h200,    0, 'h4C,  1, 'h44,   1);
    main_tbl[22] = mk(1, 0, 0,        1, 'h200, 0, 0,      1);
    main_tbl[23] = mk(1, 0, 0,        1, 'h204, 0, 0,      1);
    main_tbl[24] = mk(1, 0, 0,        1, 'h208, 1, 'h200,  1);

    // Backpressure straight out of reset, then release.
    bp_tbl[0] = mk(0, 0, 0, 1, 'h0,  0, 0,   0);
    bp_tbl[1] = mk(0, 0, 0, 1, 'h4,  0, 0,   0);
    bp_tbl[2] = mk(0, 0, 0, 0, 'h8,  1, 'h0, 0);
    bp_tbl[3] = mk(0, 0, 0, 0, 'h8,  1, 'h0, 0);
    bp_tbl[4] = mk(0, 0, 0, 0, 'h8,  1, 'h0, 0);
    bp_tbl[5] = mk(0, 0, 0, 0, 'h8,  1, 'h0, 0);
    bp_tbl[6] = mk(1, 0, 0, 1, 'h8,  1, 'h0, 0);
    bp_tbl[7] = mk(1, 0, 0, 1, 'hC,  1, 'h4, 0);
    bp_tbl[8] = mk(1, 0, 0, 1, 'h10, 1, 'h8, 0);
    bp_tbl[9] = mk(1, 0, 0, 1, 'h14, 1, 'hC, 0);

    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.out_valid", 64'(bus.out_valid), 64'h0);
    check("reset.imem_req", 64'(bus.imem_req), 64'h0);
    check("reset.fetch_pc", bus.fetch_pc, 64'h0);
    check("reset.out_pc", bus.out_pc, 64'h0);
    check("reset.out_instr", 64'(bus.out_instr), 64'h0);
    check("reset.misalign_err", 64'(bus.misalign_err), 64'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      bus.out_ready      = main_tbl[i].rdy;
      bus.redirect_valid = main_tbl[i].rv;
      bus.redirect_pc    = main_tbl[i].rpc;
      #1;
      check_row("main", i, main_tbl[i]);
      @(negedge clk);
    end

    // Reset asserted between edges while streaming with misalign_err set.
    bus.redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async.out_valid", 64'(bus.out_valid), 64'h0);
    check("async.imem_req", 64'(bus.imem_req), 64'h0);
    check("async.misalign_err", 64'(bus.misalign_err), 64'h0);
    check("async.fetch_pc", bus.fetch_pc, 64'h0);
    bus.out_ready = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.out_ready      = bp_tbl[i].rdy;
      bus.redirect_valid = bp_tbl[i].rv;
      bus.redirect_pc    = bp_tbl[i].rpc;
      #1;
      check_row("bp", i, bp_tbl[i]);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
